// File: rtl/cc_collision_manager.sv
// Collision manager for a row-based racing game: merges player and enemy-car rows,
// detects overlaps, and tracks lives with a post-hit invulnerability window.
module cc_collision_manager #(
    parameter int DATAWIDTH   = 8,
    parameter int NCARS       = 2,
    parameter int LIVES       = 3,
    parameter int INVUL_TICKS = 4
) (
    input  logic                       CC_COLLISION_MANAGER_CLOCK_50,
    input  logic                       CC_COLLISION_MANAGER_RESET_InHigh,
    input  logic                       CC_COLLISION_MANAGER_Tick_In,
    input  logic                       CC_COLLISION_MANAGER_Restart_In,
    input  logic [DATAWIDTH-1:0]       CC_COLLISION_MANAGER_PlayerData_InBus,
    input  logic [NCARS*DATAWIDTH-1:0] CC_COLLISION_MANAGER_CarData_InBus,
    output logic [DATAWIDTH-1:0]       CC_COLLISION_MANAGER_Data_OutBus,
    output logic                       CC_COLLISION_MANAGER_Hit_Out,
    output logic [NCARS-1:0]           CC_COLLISION_MANAGER_CarHit_OutBus,
    output logic [1:0]                 CC_COLLISION_MANAGER_Lives_OutBus,
    output logic                       CC_COLLISION_MANAGER_Invulnerable_Out,
    output logic                       CC_COLLISION_MANAGER_GameOver_Out
);

    localparam int CNTW = $clog2(INVUL_TICKS + 1);

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        INVUL    = 2'd1,
        GAMEOVER = 2'd2
    } state_t;

    state_t                stateReg;
    logic [CNTW-1:0]       counterReg;
    logic [1:0]            livesReg;
    logic [DATAWIDTH-1:0]  dataReg;
    logic                  hitReg;
    logic [NCARS-1:0]      carHitReg;
    logic                  invulReg;
    logic                  gameOverReg;

    logic [NCARS-1:0]      overlap;
    logic [DATAWIDTH-1:0]  merged;
    logic                  collision;

    genvar gi;
    generate
        for (gi = 0; gi < NCARS; gi++) begin : gOverlap
            assign overlap[gi] = |(CC_COLLISION_MANAGER_PlayerData_InBus &
                                   CC_COLLISION_MANAGER_CarData_InBus[gi*DATAWIDTH +: DATAWIDTH]);
        end
    endgenerate

    assign collision = |overlap;

    always_comb begin
        merged = CC_COLLISION_MANAGER_PlayerData_InBus;
        for (int i = 0; i < NCARS; i++) begin
            merged = merged | CC_COLLISION_MANAGER_CarData_InBus[i*DATAWIDTH +: DATAWIDTH];
        end
    end

    always_ff @(posedge CC_COLLISION_MANAGER_CLOCK_50 or posedge CC_COLLISION_MANAGER_RESET_InHigh) begin
        if (CC_COLLISION_MANAGER_RESET_InHigh) begin
            stateReg    <= PLAY;
            counterReg  <= '0;
            livesReg    <= LIVES[1:0];
            dataReg     <= '0;
            hitReg      <= 1'b0;
            carHitReg   <= '0;
            invulReg    <= 1'b0;
            gameOverReg <= 1'b0;
        end else begin
            // Hit is a strobe: cleared every cycle unless a counted collision re-arms it
            hitReg <= 1'b0;
            if (CC_COLLISION_MANAGER_Restart_In) begin
                stateReg    <= PLAY;
                counterReg  <= '0;
                livesReg    <= LIVES[1:0];
                dataReg     <= '0;
                carHitReg   <= '0;
                invulReg    <= 1'b0;
                gameOverReg <= 1'b0;
            end else if (CC_COLLISION_MANAGER_Tick_In) begin
                case (stateReg)
                    PLAY: begin
                        dataReg <= merged;
                        if (collision) begin
                            hitReg    <= 1'b1;
                            carHitReg <= overlap;
                            if (livesReg > 2'd1) begin
                                livesReg   <= livesReg - 2'd1;
                                counterReg <= INVUL_TICKS[CNTW-1:0];
                                stateReg   <= INVUL;
                                invulReg   <= 1'b1;
                            end else begin
                                livesReg    <= 2'd0;
                                stateReg    <= GAMEOVER;
                                gameOverReg <= 1'b1;
                            end
                        end
                    end
                    INVUL: begin
                        dataReg    <= merged;
                        counterReg <= counterReg - CNTW'(1);
                        // <= 1 also recovers safely if the counter were ever zero here
                        if (counterReg <= CNTW'(1)) begin
                            counterReg <= '0;
                            stateReg   <= PLAY;
                            invulReg   <= 1'b0;
                        end
                    end
                    GAMEOVER: begin
                        livesReg <= 2'd0;
                    end
                    default: begin
                        stateReg    <= PLAY;
                        invulReg    <= 1'b0;
                        gameOverReg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign CC_COLLISION_MANAGER_Data_OutBus      = dataReg;
    assign CC_COLLISION_MANAGER_Hit_Out          = hitReg;
    assign CC_COLLISION_MANAGER_CarHit_OutBus    = carHitReg;
    assign CC_COLLISION_MANAGER_Lives_OutBus     = livesReg;
    assign CC_COLLISION_MANAGER_Invulnerable_Out = invulReg;
    assign CC_COLLISION_MANAGER_GameOver_Out     = gameOverReg;

endmodule

// File: doc/cc_collision_manager.md
CC_COLLISION_MANAGER -- requirements
Module: CC_COLLISION_MANAGER

Interface
REQ-001 Parameter DATAWIDTH, default 8: width of one road row bitmap.
REQ-002 Parameter NCARS, default 2: number of enemy-car channels compared against the player.
REQ-003 Parameter LIVES, default 3: lives loaded at reset and restart; range 1..3.
REQ-004 Parameter INVUL_TICKS, default 4: invulnerability length in Tick_In strobes; minimum 1.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: CC_COLLISION_MANAGER_CLOCK_50 in 1, the rising-edge clock; CC_COLLISION_MANAGER_RESET_InHigh in 1, the asynchronous active-high reset.
REQ-006 CC_COLLISION_MANAGER_Tick_In in 1: one-cycle row-update strobe.
REQ-007 CC_COLLISION_MANAGER_Restart_In in 1: synchronous new-game request.
REQ-008 CC_COLLISION_MANAGER_PlayerData_InBus in DATAWIDTH: player row bitmap.
REQ-009 CC_COLLISION_MANAGER_CarData_InBus in NCARS*DATAWIDTH: car i occupies bits [i*DATAWIDTH +: DATAWIDTH].
REQ-010 CC_COLLISION_MANAGER_Data_OutBus out DATAWIDTH: registered merged row.
REQ-011 CC_COLLISION_MANAGER_Hit_Out out 1: one-cycle pulse on a counted collision.
REQ-012 CC_COLLISION_MANAGER_CarHit_OutBus out NCARS: cars involved in the last counted collision.
REQ-013 CC_COLLISION_MANAGER_Lives_OutBus out 2: remaining lives.
REQ-014 CC_COLLISION_MANAGER_Invulnerable_Out out 1: high while in state INVUL.
REQ-015 CC_COLLISION_MANAGER_GameOver_Out out 1: high while in state GAMEOVER.

Function
REQ-016 The block SHALL evaluate overlap_i = OR-reduce(PlayerData AND Car_i) combinationally; collision = OR of all overlap_i, and a zero player row never collides.
REQ-017 The block SHALL sample inputs only in cycles with Tick_In=1; all outputs SHALL update on the following clock edge (latency 1).
REQ-018 On every Tick_In outside GAMEOVER, Data_OutBus SHALL load PlayerData OR every Car_i; Data_OutBus SHALL hold in GAMEOVER.
REQ-019 The FSM SHALL have three states: PLAY, INVUL and GAMEOVER.
REQ-020 PLAY with Tick_In and collision and Lives>1: Lives decrements by 1, Hit_Out pulses, CarHit_OutBus loads the overlap vector, the invulnerability counter loads INVUL_TICKS, and the FSM goes to INVUL.
REQ-021 PLAY with Tick_In and collision and Lives=1: Lives goes to 0, Hit_Out pulses, CarHit_OutBus loads the overlap vector, and the FSM goes to GAMEOVER.
REQ-022 INVUL: collisions SHALL be ignored (no Hit_Out, no Lives change); each Tick_In decrements the counter, and the Tick that takes it 1 to 0 returns the FSM to PLAY on the next edge.
REQ-023 GAMEOVER SHALL be sticky: Tick_In is ignored, Lives stays 0, and Hit_Out stays 0.
REQ-024 Restart_In SHALL be effective in any state: next edge loads PLAY, Lives=LIVES, counter=0, CarHit_OutBus=0, Data_OutBus=0, Hit_Out=0.
REQ-025 When Restart_In and Tick_In occur in the same cycle, Restart_In SHALL have priority and the Tick SHALL be discarded.
REQ-026 Lives SHALL never underflow below 0.
REQ-027 Hit_Out SHALL never be high for two consecutive cycles.

Reset
REQ-028 While RESET_InHigh=1, asynchronously: state=PLAY, Lives=LIVES, counter=0, Data_OutBus=0, Hit_Out=0, CarHit_OutBus=0, Invulnerable_Out=0, GameOver_Out=0.
REQ-029 Reset asserted mid-INVUL or in GAMEOVER SHALL take effect immediately, without waiting for a clock edge or Tick_In.
REQ-030 After reset release, the first Tick_In SHALL be processed normally.

Verification (DATAWIDTH=8, NCARS=2, LIVES=3, INVUL_TICKS=2)
REQ-031 Reset pulse -> Lives=3, all other outputs 0, state PLAY.
REQ-032 Tick with player 8'h18, car0 8'h81, car1 8'h00 -> Data_OutBus 8'h99, Hit_Out 0, Lives 3.
REQ-033 Tick with player 8'h18, car0 8'h00, car1 8'h10 -> Hit_Out single pulse, Lives 2, CarHit_OutBus 2'b10, Invulnerable_Out 1; next colliding Tick -> no Hit_Out, Lives 2; second Tick -> Invulnerable_Out 0.
REQ-034 Three counted collisions -> Lives 0, GameOver_Out 1; further colliding Ticks -> Lives and Data_OutBus unchanged; Restart_In -> Lives 3, GameOver_Out 0.
REQ-035 Restart_In and a colliding Tick in the same cycle -> Lives=3, Hit_Out 0.
REQ-036 Reset asserted mid-clock during INVUL -> Invulnerable_Out 0 and Lives 3 before the next clock edge.
